dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the datapath's load/store port, replacing the zero-latency memory with a valid/ready request/response protocol.
- Accepts one word-sized read or write request, waits a programmable number of cycles, performs the access on internal word storage, then returns a response and holds it until it is accepted.
- Sits between the execution stage's memory-access request logic and the storage array; used as the slave model for a stall-capable pipeline.

Parameters:
- ADDR_W, 8, word-index width; depth = 2^ADDR_W words; index = req_addr[ADDR_W+1:2].
- WAIT_CYCLES, 2, wait states between acceptance and access; range 0..15.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept; equals (state==IDLE) and is forced 0 while rst_n=0.
- req_we, input, 1, 1=store, 0=load.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, requester accepts the response.
- rsp_rdata, output, 32, load data, or echoed store data for writes.
- rsp_err, output, 1, misalignment flag; exists only with DMEM_ALIGN_CHECK_EN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latched request registers are cleared.
  - Storage contents are not reset and are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_we, word index and req_wdata.
  - If WAIT_CYCLES=0: perform the access on this same edge and go to RESP.
  - Otherwise: cnt<=WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt==1: perform the access and go to RESP.
  - Otherwise: cnt<=cnt-1.
- Access:
  - Write: mem[idx]<=wdata and rsp_rdata<=wdata.
  - Read: rsp_rdata<=mem[idx].
  - Set rsp_valid<=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until handshake.
  - On an edge with rsp_ready=1: rsp_valid<=0 and go to IDLE.
- Latency: if a request is accepted on edge T, rsp_valid is high from edge T+WAIT_CYCLES onward. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles when rsp_ready is held 1.
- A new request is never accepted in the same cycle as a response handshake; req_ready is low in RESP.
- Request inputs are ignored outside IDLE, and changes to them after acceptance have no effect.
- req_addr[1:0] and address bits above ADDR_W+1 are ignored; the index wraps modulo 2^ADDR_W.
- A read issued after a write to the same index returns the new data; there is no other ordering hazard because only one request is outstanding.
- Reset mid-operation:
  - A pending (not yet performed) write is dropped.
  - An unconsumed response is discarded.
  - Writes already performed persist in storage.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - rsp_err port exists.
  - A request with req_addr[1:0]!=0 follows the same state sequence and latency, but does not write storage.
  - Its response has rsp_rdata=0 and rsp_err=1.
  - Aligned requests return rsp_err=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - No rsp_err port.
  - Low address bits are silently ignored.

Test Plan:
- Write/read, WAIT_CYCLES=2, rsp_ready=1:
  - Write addr 0x100, data 0xDEADBEEF, accepted edge T -> rsp_valid=1 at T+2 with rsp_rdata=0xDEADBEEF; req_ready=1 again at T+3.
  - Then read 0x100 -> rsp_rdata=0xDEADBEEF.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; asserting rsp_ready -> IDLE on the next edge.
- Wrap, ADDR_W=8: write 0x0000_0404 = 0x1234_5678 -> a read of 0x0000_0004 returns 0x1234_5678.
- WAIT_CYCLES=0: read accepted on edge T -> rsp_valid=1 at T; back-to-back reads complete every 2 cycles.
- Reset mid-WAIT: write 0x20 = 0xAAAA_AAAA, assert rst_n=0 while cnt=1, then write 0x20 = 0x5555_5555 and read 0x20 -> returns 0x5555_5555. Outputs read 0 and req_ready=0 during reset.
- DMEM_ALIGN_CHECK_EN:
  - Write 0x102 = 0xFFFF_FFFF -> rsp_err=1, rsp_rdata=0.
  - Read 0x100 -> previous contents unchanged, rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target; response rises WAIT_CYCLES edges after acceptance, held until rsp_ready.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests skip storage and return rsp_err=1 with zero data.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        rsp_err
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_W;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_idx_q, lat_idx_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic              lat_mis_q, lat_mis_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic              req_mis;
  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_mis;
  logic              mem_we;
  logic              unused_addr_bits;

  assign req_idx          = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |req_addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_idx_d   = lat_idx_q;
    lat_wdata_d = lat_wdata_q;
    lat_mis_d   = lat_mis_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    acc_we      = lat_we_q;
    acc_idx     = lat_idx_q;
    acc_wdata   = lat_wdata_q;
    acc_mis     = lat_mis_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_we_d    = req_we;
          lat_idx_d   = req_idx;
          lat_wdata_d = req_wdata;
          lat_mis_d   = req_mis;
          if (WAIT_CYCLES == 0) begin
            // zero wait states: access straight from the request inputs
            access    = 1'b1;
            acc_we    = req_we;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_mis   = req_mis;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) access = 1'b1;
        else               cnt_d  = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (access) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_mis;
      if (acc_mis)     rsp_rdata_d = 32'h0;
      else if (acc_we) rsp_rdata_d = acc_wdata;
      else             rsp_rdata_d = mem[acc_idx];
    end
  end

  // storage has no reset; gating with rst_n drops a write that coincides with reset
  assign mem_we = access & acc_we & ~acc_mis & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      lat_we_q    <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= 32'h0;
      lat_mis_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_idx_q   <= lat_idx_d;
      lat_wdata_q <= lat_wdata_d;
      lat_mis_q   <= lat_mis_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) & rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance driven from a vector table, WAIT_CYCLES=0 instance by hand.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_rsp_valid, z_rsp_ready;
  logic [31:0] z_rsp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        rsp_err, z_rsp_err;
`endif

  int errors = 0;
  int checks = 0;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
    , .rsp_err(rsp_err)
`endif
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
    , .rsp_err(z_rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; hold = stalled response cycles.
  task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp, input int hold);
    int lat;
    @(negedge clk);
    chk({nm, ":ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    chk({nm, ":ready_busy"}, {31'b0, req_ready}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ":latency"}, lat, 32'd2);
    chk({nm, ":rdata"}, rsp_rdata, exp);
`ifdef DMEM_ALIGN_CHECK_EN
    chk({nm, ":err"}, {31'b0, rsp_err}, {31'b0, (addr[1:0] != 2'b00)});
`endif
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = 32'h0BAD_BAD0;
      @(negedge clk);
      chk({nm, ":hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({nm, ":hold_rdata"}, rsp_rdata, exp);
      chk({nm, ":hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, ":done_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, ":done_ready"}, {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0};
    vecs[2]  = '{1'b1, 32'h0000_0404, 32'h1234_5678, 32'h1234_5678, 0};
    vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 0};
    vecs[4]  = '{1'b1, 32'hABCD_E408, 32'hCAFE_F00D, 32'hCAFE_F00D, 0};
    vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_CAFE, 0};
    vecs[8]  = '{1'b1, 32'h0000_0100, 32'h1111_2222, 32'h1111_2222, 0};
    vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h1111_2222, 5};
    vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         32'h1111_2222, 0};
    vecs[11] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:req_ready", {31'b0, req_ready}, 32'd0);
    chk("reset:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset:rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset:req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++)
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].hold);

`ifndef DMEM_ALIGN_CHECK_EN
    txn("lowbits_wr", 1'b1, 32'h0000_0203, 32'h1357_2468, 32'h1357_2468, 0);
    txn("lowbits_rd", 1'b0, 32'h0000_0200, 32'h0,         32'h1357_2468, 0);
`endif

    // Reset while the write is one edge from being performed.
    txn("rst_pre", 1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wait:req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rst_wait2:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wait2:rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    txn("rst_dropped", 1'b0, 32'h0000_0020, 32'h0, 32'h0F0F_0F0F, 0);
    txn("rst_wr",      1'b1, 32'h0000_0020, 32'h5555_5555, 32'h5555_5555, 0);
    txn("rst_rd",      1'b0, 32'h0000_0020, 32'h0, 32'h5555_5555, 0);
    txn("rst_persist", 1'b0, 32'h0000_0100, 32'h0, 32'h1111_2222, 0);

    // Reset while a response is waiting for rsp_ready.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_resp:pending", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_resp:rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp:after_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_resp:after_ready", {31'b0, req_ready}, 32'd1);

`ifdef DMEM_ALIGN_CHECK_EN
    txn("mis_wr", 1'b1, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0, 0);
    txn("mis_rd", 1'b0, 32'h0000_0100, 32'h0, 32'h1111_2222, 0);
`endif

    // WAIT_CYCLES=0 instance: response on the accepting edge, one request every 2 cycles.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h10; z_req_wdata = 32'h0000_0077; z_rsp_ready = 1'b1;
    @(negedge clk);
    chk("z_wr:rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
    chk("z_wr:rsp_rdata", z_rsp_rdata, 32'h0000_0077);
    chk("z_wr:req_ready", {31'b0, z_req_ready}, 32'd0);
    z_req_we = 1'b0; z_req_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("z_rd%0d:idle_valid", k), {31'b0, z_rsp_valid}, 32'd0);
      chk($sformatf("z_rd%0d:idle_ready", k), {31'b0, z_req_ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("z_rd%0d:rsp_valid", k), {31'b0, z_rsp_valid}, 32'd1);
      chk($sformatf("z_rd%0d:rsp_rdata", k), z_rsp_rdata, 32'h0000_0077);
    end
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_end:rsp_valid", {31'b0, z_rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
